// File: rtl/lcd_chrono_display_driver_if.sv
// Signal bundle between the stopwatch core and the LCD display driver:
// BCD digits and lap flag in, LCD pins and status strobes out.
interface lcd_chrono_display_driver_if;
  logic [15:0] fourDigitInput;
  logic        lapFlag;
  logic [1:0]  lcd_flags;
  logic [3:0]  lcd_data;
  logic        ready;
  logic        frame_done;

  modport master (
    output fourDigitInput,
    output lapFlag,
    input  lcd_flags,
    input  lcd_data,
    input  ready,
    input  frame_done
  );

  modport slave (
    input  fourDigitInput,
    input  lapFlag,
    output lcd_flags,
    output lcd_data,
    output ready,
    output frame_done
  );
endinterface

// File: rtl/lcd_chrono_display_driver.sv
// HD44780 4-bit driver: power-on init, config, then endless refresh of line 1 with
// "D3D2.D1D0" plus "LAP" or blanks, using a snapshot taken at the start of each frame.
module lcd_chrono_display_driver #(
  parameter int T_PWR     = 750000,
  parameter int T_INIT1   = 205000,
  parameter int T_INIT2   = 5000,
  parameter int T_CMD     = 2000,
  parameter int T_CLR     = 82000,
  parameter int T_SU      = 2,
  parameter int T_EH      = 12,
  parameter int T_EL      = 50,
  parameter int T_REFRESH = 500000
) (
  input  logic                        qzt_clk,
  input  logic                        reset_n,
  lcd_chrono_display_driver_if.slave  bus
);

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int T_MAX = imax(imax(imax(T_PWR, T_INIT1), imax(T_INIT2, T_CMD)),
                              imax(imax(T_CLR, T_SU), imax(imax(T_EH, T_EL), T_REFRESH)));
  localparam int CW = $clog2(T_MAX + 1);

  typedef enum logic [2:0] {
    ST_PWR_WAIT = 3'd0,
    ST_INIT     = 3'd1,
    ST_CFG      = 3'd2,
    ST_FRAME    = 3'd3,
    ST_GAP      = 3'd4
  } state_e;

  // Sub-phase of one nibble transfer; PH_WT is the post-byte (or post-nibble) wait.
  typedef enum logic [1:0] {
    PH_SU = 2'd0,
    PH_EH = 2'd1,
    PH_EL = 2'd2,
    PH_WT = 2'd3
  } phase_e;

  function automatic logic [7:0] digit_char(input logic [3:0] d);
    return (d > 4'd9) ? 8'h2D : {4'h3, d};
  endfunction

  state_e          state_q, state_d;
  phase_e          ph_q, ph_d;
  logic            hi_q, hi_d;
  logic [3:0]      idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ready_q, ready_d;
  logic [16:0]     snap_q, snap_d;

  logic [CW-1:0]   wait_c;
  logic [CW-1:0]   lim_c;
  logic            expire_c;
  logic            last_c;
  logic [7:0]      byte_c;
  logic            e_c;
  logic            rs_c;
  logic [3:0]      db_c;
  logic            fd_c;

  // Duration of whatever the sequencer is currently doing.
  always_comb begin
    wait_c = CW'(T_CMD);
    if (state_q == ST_INIT && idx_q == 4'd0) begin
      wait_c = CW'(T_INIT1);
    end else if (state_q == ST_INIT && idx_q == 4'd1) begin
      wait_c = CW'(T_INIT2);
    end else if (state_q == ST_CFG && idx_q == 4'd3) begin
      wait_c = CW'(T_CLR);
    end

    lim_c = CW'(T_SU);
    case (state_q)
      ST_PWR_WAIT: lim_c = CW'(T_PWR);
      ST_GAP:      lim_c = CW'(T_REFRESH);
      default: begin
        case (ph_q)
          PH_SU:   lim_c = CW'(T_SU);
          PH_EH:   lim_c = CW'(T_EH);
          PH_EL:   lim_c = CW'(T_EL);
          default: lim_c = wait_c;
        endcase
      end
    endcase
  end

  assign expire_c = (cnt_q == lim_c - CW'(1));
  assign last_c   = (state_q == ST_FRAME) ? (idx_q == 4'd10) : (idx_q == 4'd3);

  // Byte (or single init nibble in the low half) for the current step.
  always_comb begin
    byte_c = 8'h00;
    case (state_q)
      ST_INIT: byte_c = (idx_q == 4'd3) ? 8'h02 : 8'h03;
      ST_CFG: begin
        case (idx_q)
          4'd0:    byte_c = 8'h28;
          4'd1:    byte_c = 8'h0C;
          4'd2:    byte_c = 8'h06;
          default: byte_c = 8'h01;
        endcase
      end
      ST_FRAME: begin
        case (idx_q)
          4'd0:    byte_c = 8'h80;
          4'd1:    byte_c = digit_char(snap_q[15:12]);
          4'd2:    byte_c = digit_char(snap_q[11:8]);
          4'd3:    byte_c = 8'h2E;
          4'd4:    byte_c = digit_char(snap_q[7:4]);
          4'd5:    byte_c = digit_char(snap_q[3:0]);
          4'd7:    byte_c = snap_q[16] ? 8'h4C : 8'h20;
          4'd8:    byte_c = snap_q[16] ? 8'h41 : 8'h20;
          4'd9:    byte_c = snap_q[16] ? 8'h50 : 8'h20;
          default: byte_c = 8'h20;
        endcase
      end
      default: byte_c = 8'h00;
    endcase
  end

  always_ff @(posedge qzt_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_PWR_WAIT;
      ph_q    <= PH_SU;
      hi_q    <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      hi_q    <= hi_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      snap_q  <= snap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    hi_d    = hi_q;
    idx_d   = idx_q;
    cnt_d   = expire_c ? '0 : cnt_q + CW'(1);

    if (expire_c) begin
      case (state_q)
        ST_PWR_WAIT: begin
          state_d = ST_INIT;
          ph_d    = PH_SU;
          hi_d    = 1'b0;
          idx_d   = '0;
        end
        ST_GAP: begin
          state_d = ST_FRAME;
          ph_d    = PH_SU;
          hi_d    = 1'b1;
          idx_d   = '0;
        end
        default: begin
          case (ph_q)
            PH_SU: ph_d = PH_EH;
            PH_EH: ph_d = PH_EL;
            PH_EL: begin
              ph_d = hi_q ? PH_SU : PH_WT;
              hi_d = 1'b0;
            end
            default: begin
              ph_d = PH_SU;
              if (!last_c) begin
                idx_d = idx_q + 4'd1;
                hi_d  = (state_q != ST_INIT);
              end else begin
                idx_d = '0;
                hi_d  = 1'b1;
                case (state_q)
                  ST_INIT: state_d = ST_CFG;
                  ST_CFG:  state_d = ST_FRAME;
                  default: state_d = ST_GAP;
                endcase
              end
            end
          endcase
        end
      endcase
    end

    // Inputs are frozen on frame entry so a frame never mixes two counts.
    ready_d = ready_q | (state_d == ST_FRAME);
    snap_d  = (state_d == ST_FRAME && state_q != ST_FRAME) ?
              {bus.lapFlag, bus.fourDigitInput} : snap_q;
  end

  always_comb begin
    e_c  = 1'b0;
    rs_c = 1'b0;
    db_c = 4'h0;
    if (state_q inside {ST_INIT, ST_CFG, ST_FRAME} && ph_q != PH_WT) begin
      rs_c = (state_q == ST_FRAME) && (idx_q != 4'd0);
      db_c = hi_q ? byte_c[7:4] : byte_c[3:0];
      e_c  = (ph_q == PH_EH);
    end
    fd_c = (state_q == ST_FRAME) && (ph_q == PH_WT) && last_c && expire_c;
  end

  assign bus.lcd_flags  = {rs_c, e_c};
  assign bus.lcd_data   = db_c;
  assign bus.ready      = ready_q;
  assign bus.frame_done = fd_c;

endmodule

// File: tb/tb_lcd_chrono_display_driver.sv
// Directed bench for the LCD display driver: records every E pulse and decodes the
// nibble stream into init, config and frame bytes against hand-computed values.
module tb_lcd_chrono_display_driver;
  localparam int T_PWR     = 100;
  localparam int T_INIT1   = 40;
  localparam int T_INIT2   = 20;
  localparam int T_CMD     = 10;
  localparam int T_CLR     = 30;
  localparam int T_SU      = 1;
  localparam int T_EH      = 2;
  localparam int T_EL      = 3;
  localparam int T_REFRESH = 50;
  localparam int NIB_INIT  = 12;   // 4 init nibbles + 4 config bytes
  localparam int NIB_FRAME = 22;   // 11 bytes per frame

  logic qzt_clk = 1'b0;
  logic reset_n = 1'b1;

  lcd_chrono_display_driver_if bus ();

  lcd_chrono_display_driver #(
    .T_PWR(T_PWR), .T_INIT1(T_INIT1), .T_INIT2(T_INIT2), .T_CMD(T_CMD), .T_CLR(T_CLR),
    .T_SU(T_SU), .T_EH(T_EH), .T_EL(T_EL), .T_REFRESH(T_REFRESH)
  ) dut (
    .qzt_clk(qzt_clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 qzt_clk = ~qzt_clk;

  typedef struct packed {
    logic       rs;
    logic [3:0] d;
    int         t_rise;
    int         t_fall;
    logic       stable;
  } nib_t;

  nib_t nibs[$];
  int   fd_cycs[$];
  int   ready_cyc = -1;
  int   cyc = 0;
  int   tests_run = 0;
  int   tests_failed = 0;

  initial begin : cycle_counter
    forever begin
      @(posedge qzt_clk);
      cyc = reset_n ? cyc + 1 : 0;
    end
  end

  initial begin : monitor
    nib_t cur;
    logic e_prev;
    cur = '0;
    e_prev = 1'b0;
    forever begin
      @(negedge qzt_clk);
      if (!reset_n) begin
        nibs.delete();
        fd_cycs.delete();
        ready_cyc = -1;
        e_prev = 1'b0;
      end else begin
        if (bus.lcd_flags[0] === 1'b1 && !e_prev) begin
          cur.rs = bus.lcd_flags[1];
          cur.d = bus.lcd_data;
          cur.t_rise = cyc;
          cur.t_fall = 0;
          cur.stable = 1'b1;
        end else if (bus.lcd_flags[0] === 1'b1) begin
          if (bus.lcd_flags[1] !== cur.rs || bus.lcd_data !== cur.d) cur.stable = 1'b0;
        end else if (e_prev) begin
          cur.t_fall = cyc;
          if (bus.lcd_flags[1] !== cur.rs || bus.lcd_data !== cur.d) cur.stable = 1'b0;
          nibs.push_back(cur);
        end
        if (bus.ready === 1'b1 && ready_cyc < 0) ready_cyc = cyc;
        if (bus.frame_done === 1'b1) fd_cycs.push_back(cyc);
        e_prev = (bus.lcd_flags[0] === 1'b1);
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1);
  end

  task automatic wait_nibs(input int n);
    int budget = 4000;
    while (nibs.size() < n && budget > 0) begin
      @(negedge qzt_clk);
      budget--;
    end
    tests_run++;
    if (nibs.size() < n) begin
      tests_failed++;
      $display("FAIL wait_nibs: got %0d nibbles, required %0d", nibs.size(), n);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $fatal(1);
    end
  endtask

  task automatic wait_fd(input int n);
    int budget = 4000;
    while (fd_cycs.size() < n && budget > 0) begin
      @(negedge qzt_clk);
      budget--;
    end
    tests_run++;
    if (fd_cycs.size() < n) begin
      tests_failed++;
      $display("FAIL wait_frame_done: got %0d pulses, required %0d", fd_cycs.size(), n);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $fatal(1);
    end
  endtask

  function automatic logic [7:0] byte_of(input int f, input int b);
    int n = NIB_INIT + NIB_FRAME * f + 2 * b;
    return {nibs[n].d, nibs[n + 1].d};
  endfunction

  task automatic print_frame(input int f);
    $display("[TB] frame %0d: %h %h %h %h %h %h %h %h %h %h %h", f,
             byte_of(f, 0), byte_of(f, 1), byte_of(f, 2), byte_of(f, 3), byte_of(f, 4),
             byte_of(f, 5), byte_of(f, 6), byte_of(f, 7), byte_of(f, 8), byte_of(f, 9),
             byte_of(f, 10));
  endtask

  task automatic test_reset();
    bus.fourDigitInput = 16'h1234;
    bus.lapFlag = 1'b0;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge qzt_clk);
    tests_run++;
    if (bus.lcd_flags !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b, required 00", bus.lcd_flags);
    end
    tests_run++;
    if (bus.lcd_data !== 4'h0) begin
      tests_failed++;
      $display("FAIL reset_data: got %h, required 0", bus.lcd_data);
    end
    tests_run++;
    if (bus.ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ready: got %b, required 0", bus.ready);
    end
    tests_run++;
    if (bus.frame_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_frame_done: got %b, required 0", bus.frame_done);
    end
    #1 reset_n = 1'b1;
    $display("[TB] reset released");
  endtask

  task automatic test_init();
    logic [3:0] exp_d [4] = '{4'h3, 4'h3, 4'h3, 4'h2};
    // E-low span between pulses = T_EL + wait + T_SU: 3+40+1, 3+20+1, 3+10+1
    int exp_gap [3] = '{44, 24, 14};
    wait_nibs(4);
    tests_run++;
    if (nibs[0].t_rise !== 101) begin
      tests_failed++;
      $display("FAIL init_first_e: E rose at cycle %0d, required 101", nibs[0].t_rise);
    end
    for (int i = 0; i < 4; i++) begin
      $display("[TB] init nibble %0d: rs=%b d=%h rise=%0d", i, nibs[i].rs, nibs[i].d, nibs[i].t_rise);
      tests_run++;
      if (nibs[i].d !== exp_d[i] || nibs[i].rs !== 1'b0) begin
        tests_failed++;
        $display("FAIL init_nibble%0d: got rs=%b d=%h, required rs=0 d=%h", i, nibs[i].rs, nibs[i].d, exp_d[i]);
      end
      tests_run++;
      if (nibs[i].t_fall - nibs[i].t_rise !== T_EH || nibs[i].stable !== 1'b1) begin
        tests_failed++;
        $display("FAIL init_pulse%0d: width %0d stable %b, required width 2 stable 1",
                 i, nibs[i].t_fall - nibs[i].t_rise, nibs[i].stable);
      end
    end
    for (int i = 1; i < 4; i++) begin
      tests_run++;
      if (nibs[i].t_rise - nibs[i-1].t_fall !== exp_gap[i-1]) begin
        tests_failed++;
        $display("FAIL init_gap%0d: got %0d, required %0d", i, nibs[i].t_rise - nibs[i-1].t_fall, exp_gap[i-1]);
      end
    end
  endtask

  task automatic test_config();
    logic [7:0] exp_b [4] = '{8'h28, 8'h0C, 8'h06, 8'h01};
    int budget = 200;
    wait_nibs(12);
    tests_run++;
    if (nibs[4].t_rise - nibs[3].t_fall !== 14) begin
      tests_failed++;
      $display("FAIL cfg_first_gap: got %0d, required 14", nibs[4].t_rise - nibs[3].t_fall);
    end
    for (int b = 0; b < 4; b++) begin
      int k = 4 + 2 * b;
      $display("[TB] config byte %0d: %h", b, {nibs[k].d, nibs[k+1].d});
      tests_run++;
      if ({nibs[k].d, nibs[k+1].d} !== exp_b[b] || nibs[k].rs !== 1'b0 || nibs[k+1].rs !== 1'b0) begin
        tests_failed++;
        $display("FAIL cfg_byte%0d: got %h rs=%b%b, required %h rs=00", b,
                 {nibs[k].d, nibs[k+1].d}, nibs[k].rs, nibs[k+1].rs, exp_b[b]);
      end
      tests_run++;
      if (nibs[k+1].t_rise - nibs[k].t_fall !== T_EL + T_SU) begin
        tests_failed++;
        $display("FAIL cfg_nibble_gap%0d: got %0d, required 4", b, nibs[k+1].t_rise - nibs[k].t_fall);
      end
      if (b < 3) begin
        tests_run++;
        if (nibs[k+2].t_rise - nibs[k+1].t_fall !== 14) begin
          tests_failed++;
          $display("FAIL cfg_byte_gap%0d: got %0d, required 14", b, nibs[k+2].t_rise - nibs[k+1].t_fall);
        end
      end
    end
    while (ready_cyc < 0 && budget > 0) begin
      @(negedge qzt_clk);
      budget--;
    end
    // ready rises after EL (3) plus the clear wait (30)
    tests_run++;
    if (ready_cyc < 0 || ready_cyc - nibs[11].t_fall !== 33) begin
      tests_failed++;
      $display("FAIL cfg_ready_timing: got %0d after last fall, required 33", ready_cyc - nibs[11].t_fall);
    end
  endtask

  task automatic test_frame_nolap();
    logic [7:0] exp_b [11] = '{8'h80, 8'h31, 8'h32, 8'h2E, 8'h33, 8'h34,
                                8'h20, 8'h20, 8'h20, 8'h20, 8'h20};
    bit all_stable = 1'b1;
    wait_nibs(NIB_INIT + NIB_FRAME);
    wait_fd(1);
    print_frame(0);
    for (int b = 0; b < 11; b++) begin
      int k = NIB_INIT + 2 * b;
      logic exp_rs = (b != 0);
      tests_run++;
      if (byte_of(0, b) !== exp_b[b]) begin
        tests_failed++;
        $display("FAIL frame0_byte%0d: got %h, required %h", b, byte_of(0, b), exp_b[b]);
      end
      tests_run++;
      if (nibs[k].rs !== exp_rs || nibs[k+1].rs !== exp_rs) begin
        tests_failed++;
        $display("FAIL frame0_rs%0d: got %b%b, required %b%b", b, nibs[k].rs, nibs[k+1].rs, exp_rs, exp_rs);
      end
      if (!nibs[k].stable || !nibs[k+1].stable) all_stable = 1'b0;
    end
    tests_run++;
    if (all_stable !== 1'b1) begin
      tests_failed++;
      $display("FAIL frame0_stable: got %b, required 1", all_stable);
    end
    tests_run++;
    if (nibs[NIB_INIT].t_rise - ready_cyc !== T_SU) begin
      tests_failed++;
      $display("FAIL frame0_start: got %0d, required 1", nibs[NIB_INIT].t_rise - ready_cyc);
    end
    // frame_done on the last wait cycle: EL (3) + T_CMD (10) - 1
    tests_run++;
    if (fd_cycs[0] - nibs[NIB_INIT + NIB_FRAME - 1].t_fall !== 12) begin
      tests_failed++;
      $display("FAIL frame0_done_timing: got %0d, required 12", fd_cycs[0] - nibs[NIB_INIT + NIB_FRAME - 1].t_fall);
    end
    @(negedge qzt_clk);
    tests_run++;
    if (fd_cycs.size() !== 1) begin
      tests_failed++;
      $display("FAIL frame0_done_width: got %0d pulses, required 1", fd_cycs.size());
    end
  endtask

  task automatic test_lap();
    logic [7:0] exp_b [11] = '{8'h80, 8'h30, 8'h39, 8'h2E, 8'h30, 8'h37,
                                8'h20, 8'h4C, 8'h41, 8'h50, 8'h20};
    bus.fourDigitInput = 16'h0907;
    bus.lapFlag = 1'b1;
    wait_nibs(NIB_INIT + 2 * NIB_FRAME);
    wait_fd(2);
    print_frame(1);
    for (int b = 0; b < 11; b++) begin
      tests_run++;
      if (byte_of(1, b) !== exp_b[b]) begin
        tests_failed++;
        $display("FAIL lap_byte%0d: got %h, required %h", b, byte_of(1, b), exp_b[b]);
      end
    end
    // EL 3 + T_CMD 10 + T_REFRESH 50 + T_SU 1
    tests_run++;
    if (nibs[NIB_INIT + NIB_FRAME].t_rise - nibs[NIB_INIT + NIB_FRAME - 1].t_fall !== 64) begin
      tests_failed++;
      $display("FAIL refresh_gap: got %0d, required 64",
               nibs[NIB_INIT + NIB_FRAME].t_rise - nibs[NIB_INIT + NIB_FRAME - 1].t_fall);
    end
    // 11 bytes * 22 cycles + 50 idle
    tests_run++;
    if (fd_cycs[1] - fd_cycs[0] !== 292) begin
      tests_failed++;
      $display("FAIL frame_period: got %0d, required 292", fd_cycs[1] - fd_cycs[0]);
    end
  endtask

  task automatic test_coherence();
    int digit_pos [4] = '{1, 2, 4, 5};
    bus.fourDigitInput = 16'h1111;
    bus.lapFlag = 1'b0;
    wait_nibs(NIB_INIT + 2 * NIB_FRAME + 6);
    bus.fourDigitInput = 16'h2222;
    wait_nibs(NIB_INIT + 3 * NIB_FRAME);
    wait_fd(3);
    print_frame(2);
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (byte_of(2, digit_pos[i]) !== 8'h31) begin
        tests_failed++;
        $display("FAIL coherent_old%0d: got %h, required 31", i, byte_of(2, digit_pos[i]));
      end
    end
    wait_nibs(NIB_INIT + 4 * NIB_FRAME);
    wait_fd(4);
    print_frame(3);
    bus.fourDigitInput = 16'hA000;
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (byte_of(3, digit_pos[i]) !== 8'h32) begin
        tests_failed++;
        $display("FAIL coherent_new%0d: got %h, required 32", i, byte_of(3, digit_pos[i]));
      end
    end
    wait_nibs(NIB_INIT + 5 * NIB_FRAME);
    print_frame(4);
    tests_run++;
    if (byte_of(4, 1) !== 8'h2D) begin
      tests_failed++;
      $display("FAIL invalid_digit: got %h, required 2d", byte_of(4, 1));
    end
    tests_run++;
    if (byte_of(4, 2) !== 8'h30 || byte_of(4, 5) !== 8'h30 || byte_of(4, 7) !== 8'h20) begin
      tests_failed++;
      $display("FAIL invalid_frame_rest: got %h %h %h, required 30 30 20",
               byte_of(4, 2), byte_of(4, 5), byte_of(4, 7));
    end
  endtask

  task automatic test_reset_mid();
    int budget = 2000;
    while (!(bus.lcd_flags === 2'b11) && budget > 0) begin
      @(negedge qzt_clk);
      budget--;
    end
    tests_run++;
    if (bus.lcd_flags !== 2'b11) begin
      tests_failed++;
      $display("FAIL midreset_find_e: got flags %b, required 11", bus.lcd_flags);
    end
    #1 reset_n = 1'b0;
    #1;
    tests_run++;
    if (bus.lcd_flags !== 2'b00 || bus.lcd_data !== 4'h0) begin
      tests_failed++;
      $display("FAIL midreset_async: got flags %b data %h, required 00 0", bus.lcd_flags, bus.lcd_data);
    end
    tests_run++;
    if (bus.ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_ready: got %b, required 0", bus.ready);
    end
    repeat (3) @(negedge qzt_clk);
    #1 reset_n = 1'b1;
    $display("[TB] reset released after mid-frame abort");
    wait_nibs(4);
    tests_run++;
    if (nibs[0].t_rise !== 101) begin
      tests_failed++;
      $display("FAIL reinit_first_e: got %0d, required 101", nibs[0].t_rise);
    end
    tests_run++;
    if ({nibs[0].d, nibs[1].d, nibs[2].d, nibs[3].d} !== 16'h3332 ||
        {nibs[0].rs, nibs[1].rs, nibs[2].rs, nibs[3].rs} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reinit_nibbles: got %h%h%h%h, required 3332",
               nibs[0].d, nibs[1].d, nibs[2].d, nibs[3].d);
    end
    tests_run++;
    if (bus.ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reinit_ready: got %b, required 0", bus.ready);
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_config();
    test_frame_nolap();
    test_lap();
    test_coherence();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
